mult_datapath: RTL

Register/adder datapath for the shift-add multiplier. It sits directly downstream of `sequencer` and consumes its `reset`, `shift` and `add_shift` control strobes. It returns `Q0` to the sequencer and latches the finished 2n-bit product for readout on the shared 8-bit board bus. Operands are loaded from the same bus.

---
 rtl/mult_pkg.sv | 13 +
 rtl/shift_adder.sv | 21 ++
 rtl/mult_datapath.sv | 112 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: operand width and the
// control-strobe bundle exchanged between sequencer and datapath.
package mult_pkg;

  localparam int unsigned MULT_N = 8;

  typedef struct packed {
    logic clear;
    logic shift;
    logic add_shift;
  } ctrl_t;

endpackage

// File: rtl/shift_adder.sv
// Combinational step unit: optional A+M with carry, then right shift of {carry,A,Q}.
module shift_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] m_i,
  input  logic [N-1:1] q_hi_i,
  input  logic         add_i,
  output logic [N-1:0] a_o,
  output logic [N-1:0] q_o
);

  logic [N:0] sum;

  always_comb begin
    sum = add_i ? ({1'b0, a_i} + {1'b0, m_i}) : {1'b0, a_i};
    // Carry lands in A's MSB; the bit shifted out of A becomes Q's MSB.
    {a_o, q_o} = {sum, q_hi_i};
  end

endmodule

// File: rtl/mult_datapath.sv
// Register/adder datapath of the shift-add multiplier: operand latches, A/Q
// working registers, step counter and the latched 2n-bit product.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           shift_i,
  input  logic           add_shift_i,
  input  logic           ld_m_i,
  input  logic           ld_q_i,
  input  logic [N-1:0]   data_in_i,
  input  logic           sel_hi_i,
  output logic           q0_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [2*N-1:0] product_o,
  output logic [N-1:0]   data_out_o
);

  localparam int unsigned CntW = $clog2(N + 1);

  logic [N-1:0]   m_q, m_d, qin_q, qin_d, a_q, a_d, q_q, q_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2*N-1:0] product_q, product_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N-1:0]   a_step, q_step;
  ctrl_t          ctrl;

  assign ctrl    = '{clear: clear_i, shift: shift_i, add_shift: add_shift_i};
  assign cnt_inc = cnt_q + CntW'(1);

  shift_adder #(.N(N)) u_shift_adder (
    .a_i    (a_q),
    .m_i    (m_q),
    .q_hi_i (q_q[N-1:1]),
    .add_i  (ctrl.add_shift),
    .a_o    (a_step),
    .q_o    (q_step)
  );

  always_comb begin
    m_d       = m_q;
    qin_d     = qin_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (!busy_q) begin
      if (ld_m_i) m_d = data_in_i;
      if (ld_q_i) qin_d = data_in_i;
    end

    if (ctrl.clear) begin
      a_d    = '0;
      q_d    = qin_q;
      cnt_d  = '0;
      busy_d = 1'b1;
      err_d  = 1'b0;
    end else if (busy_q && (ctrl.shift || ctrl.add_shift)) begin
      a_d   = a_step;
      q_d   = q_step;
      cnt_d = cnt_inc;
      if (ctrl.shift && ctrl.add_shift) err_d = 1'b1;
      if (cnt_inc == CntW'(N)) begin
        product_d = {a_step, q_step};
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q       <= '0;
      qin_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m_q       <= m_d;
      qin_q     <= qin_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign q0_o       = q_q[0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign product_o  = product_q;
  assign data_out_o = sel_hi_i ? product_q[2*N-1:N] : product_q[N-1:0];

endmodule
